// File: rtl/regbank_wr_sched_if.sv
// Write-side bundle between the two writeback requesters, the clear control and the
// register-bank write port. The scheduler takes the slave side.
interface regbank_wr_sched_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              clr_start;
    logic              clr_busy;
    logic              clr_done;

    logic              req0_valid;
    logic [ADDR_W-1:0] req0_dr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;

    logic              req1_valid;
    logic [ADDR_W-1:0] req1_dr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              grant_id;

    modport slave (
        input  clr_start,
        input  req0_valid, req0_dr, req0_data,
        input  req1_valid, req1_dr, req1_data,
        output clr_busy, clr_done,
        output req0_ready, req1_ready,
        output wr_en, wr_addr, wr_data, grant_id
    );

    modport master (
        output clr_start,
        output req0_valid, req0_dr, req0_data,
        output req1_valid, req1_dr, req1_data,
        input  clr_busy, clr_done,
        input  req0_ready, req1_ready,
        input  wr_en, wr_addr, wr_data, grant_id
    );
endinterface

// File: rtl/regbank_wr_sched.sv
// Single write port scheduler for the register bank: round-robin between two
// writeback requesters, plus a sequencer that walks every register writing CLR_VAL.
module regbank_wr_sched #(
    parameter int                 DATA_W  = 32,
    parameter int                 ADDR_W  = 5,
    parameter int                 NREGS   = 32,
    parameter logic [DATA_W-1:0]  CLR_VAL = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    regbank_wr_sched_if.slave     bus
);
    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NREGS - 1);

    logic [0:0]        state_q,   state_d;
    logic [ADDR_W-1:0] cnt_q,     cnt_d;
    logic              last_q,    last_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              gid_q,     gid_d;
    logic              done_q,    done_d;

    logic              ready0, ready1;
    logic              xfer0,  xfer1;

    // last_q holds the most recent grantee; the other requester wins a tie.
    always_comb begin
        ready0 = 1'b0;
        ready1 = 1'b0;
        if (reset && state_q == ST_ARB && !bus.clr_start) begin
            if (bus.req0_valid && !bus.req1_valid) begin
                ready0 = 1'b1;
            end else if (bus.req1_valid && !bus.req0_valid) begin
                ready1 = 1'b1;
            end else if (bus.req0_valid && bus.req1_valid) begin
                ready0 = last_q;
                ready1 = !last_q;
            end
        end
    end

    assign xfer0 = bus.req0_valid && ready0;
    assign xfer1 = bus.req1_valid && ready1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        gid_d     = gid_q;
        done_d    = 1'b0;

        if (state_q == ST_CLEAR) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = CLR_VAL;
            if (cnt_q == CNT_LAST) begin
                done_d  = 1'b1;
                state_d = ST_ARB;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.clr_start) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (xfer0) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.req0_dr;
            wr_data_d = bus.req0_data;
            gid_d     = 1'b0;
            last_d    = 1'b0;
        end else if (xfer1) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.req1_dr;
            wr_data_d = bus.req1_data;
            gid_d     = 1'b1;
            last_d    = 1'b1;
        end
    end

    // Reset drops wr_en on the same edge, so an aborted walk leaves later registers intact.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_ARB;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            gid_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            gid_q     <= gid_d;
            done_q    <= done_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.clr_busy   = (state_q == ST_CLEAR);
    assign bus.clr_done   = done_q;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.grant_id   = gid_q;
endmodule

// File: tb/tb_regbank_wr_sched.sv
// Scoreboard bench: stimulus pushes expected bank writes, a negedge monitor pops and
// compares them; a behavioural 32x32 bank provides readback.
module tb_regbank_wr_sched;
    logic clk;
    logic reset;

    regbank_wr_sched_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    regbank_wr_sched #(.DATA_W(32), .ADDR_W(5), .NREGS(32), .CLR_VAL(32'd0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        gid;
        bit          chk_gid;
        bit          done;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] bank [32];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_en === 1'b1) bank[bus.wr_addr] <= bus.wr_data;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.wr_en === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr=%0d data=%0h expected no write",
                         bus.wr_addr, bus.wr_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.wr_addr !== e.addr || bus.wr_data !== e.data ||
                    (e.chk_gid && bus.grant_id !== e.gid) || bus.clr_done !== e.done) begin
                    errors++;
                    $display("FAIL write: got addr=%0d data=%0h gid=%0b done=%0b expected addr=%0d data=%0h gid=%0b done=%0b",
                             bus.wr_addr, bus.wr_data, bus.grant_id, bus.clr_done,
                             e.addr, e.data, e.gid, e.done);
                end else begin
                    $display("WR addr=%0d data=%0h gid=%0b done=%0b",
                             bus.wr_addr, bus.wr_data, bus.grant_id, bus.clr_done);
                end
            end
        end else if (bus.clr_done === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL clr_done_alone: got 1 expected 0");
        end
    end

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input logic g);
        exp_t e;
        e.addr = a; e.data = d; e.gid = g; e.chk_gid = 1'b1; e.done = 1'b0;
        exp_q.push_back(e);
    endtask

    task automatic push_clear(input int n, input bit with_done);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.addr = 5'(k); e.data = 32'd0; e.gid = 1'b0; e.chk_gid = 1'b0;
            e.done = with_done && (k == 31);
            exp_q.push_back(e);
        end
    endtask

    // Called at a negedge with both requesters idle; returns at the next negedge.
    task automatic single0(input logic [4:0] a, input logic [31:0] d);
        bus.req0_valid = 1'b1;
        bus.req0_dr    = a;
        bus.req0_data  = d;
        #1;
        chk("single_ready0", bus.req0_ready, 1'b1);
        push_wr(a, d, 1'b0);
        @(negedge clk);
        bus.req0_valid = 1'b0;
    endtask

    task automatic preload_all();
        for (int k = 0; k < 32; k++) single0(5'(k), 32'(10 * k));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  i0, i1, busy_cnt;
        bit  v0, v1, exp_g, found;

        reset = 1'b0;
        bus.clr_start  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_dr = 5'd1; bus.req0_data = 32'd11;
        bus.req1_valid = 1'b0; bus.req1_dr = 5'd0; bus.req1_data = 32'd0;

        // Reset held with req0 pending: nothing may be accepted or written.
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready0", bus.req0_ready, 1'b0);
            chk("rst_wr_en", bus.wr_en, 1'b0);
            chk("rst_clr_busy", bus.clr_busy, 1'b0);
            chk("rst_clr_done", bus.clr_done, 1'b0);
        end
        reset = 1'b1;
        #1;
        chk("post_rst_ready0", bus.req0_ready, 1'b1);
        push_wr(5'd1, 32'd11, 1'b0);
        @(negedge clk);
        bus.req0_valid = 1'b0;

        // Single writer.
        single0(5'd5, 32'd50);
        @(negedge clk);
        chk("rb_reg5", bank[5], 32'd50);

        // Contention: last grant went to req0, so req1 wins the first tie.
        i0 = 0; i1 = 0;
        for (int c = 0; c < 16; c++) begin
            v0 = (i0 < 8); v1 = (i1 < 8);
            bus.req0_valid = v0; bus.req0_dr = 5'(2 * i0);     bus.req0_data = 32'(20 * i0);
            bus.req1_valid = v1; bus.req1_dr = 5'(2 * i1 + 1); bus.req1_data = 32'(10 * (2 * i1 + 1));
            exp_g = v1 && (!v0 || (c % 2 == 0));
            #1;
            chk("cont_ready0", bus.req0_ready, !exp_g);
            chk("cont_ready1", bus.req1_ready, exp_g);
            if (exp_g) begin
                push_wr(5'(2 * i1 + 1), 32'(10 * (2 * i1 + 1)), 1'b1);
                i1++;
            end else begin
                push_wr(5'(2 * i0), 32'(20 * i0), 1'b0);
                i0++;
            end
            @(negedge clk);
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 16; k++) chk($sformatf("rb_cont_reg%0d", k), bank[k], 32'(10 * k));

        // Full clear after preloading every register.
        for (int k = 16; k < 32; k++) single0(5'(k), 32'(10 * k));
        repeat (2) @(negedge clk);
        chk("rb_pre_reg31", bank[31], 32'd310);
        bus.clr_start = 1'b1;
        push_clear(32, 1'b1);
        @(negedge clk);
        bus.clr_start = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.clr_busy === 1'b1) busy_cnt++;
            @(negedge clk);
        end
        chk("clr_busy_cycles", busy_cnt, 32'd32);
        for (int k = 0; k < 32; k++) chk($sformatf("rb_clr_reg%0d", k), bank[k], 32'd0);

        // Clear and request together: request waits for the whole walk.
        bus.clr_start  = 1'b1;
        bus.req1_valid = 1'b1; bus.req1_dr = 5'd7; bus.req1_data = 32'd70;
        #1;
        chk("cvr_ready1_start", bus.req1_ready, 1'b0);
        push_clear(32, 1'b1);
        push_wr(5'd7, 32'd70, 1'b1);
        @(negedge clk);
        bus.clr_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            #1;
            if (bus.clr_busy === 1'b1) begin
                chk("cvr_ready1_busy", bus.req1_ready, 1'b0);
                @(negedge clk);
            end else begin
                chk("cvr_ready1_first_arb", bus.req1_ready, 1'b1);
                found = 1'b1;
            end
        end
        chk("cvr_clear_ended", found, 1'b1);
        @(negedge clk);
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rb_cvr_reg7", bank[7], 32'd70);
        chk("rb_cvr_reg6", bank[6], 32'd0);

        // Reset in the middle of a clear.
        preload_all();
        bus.clr_start = 1'b1;
        push_clear(11, 1'b0);
        @(negedge clk);
        bus.clr_start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.wr_en === 1'b1 && bus.wr_addr == 5'd10) found = 1'b1;
        end
        chk("mid_reached_addr10", found, 1'b1);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_wr_en", bus.wr_en, 1'b0);
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("mid_post_wr_en", bus.wr_en, 1'b0);
            chk("mid_post_busy", bus.clr_busy, 1'b0);
        end
        for (int k = 0; k < 32; k++)
            chk($sformatf("rb_mid_reg%0d", k), bank[k], (k <= 10) ? 32'd0 : 32'(10 * k));

        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
